alu_seq_core: RTL and testbench
===============================

# alu_seq_core

Parametrised, multi-cycle ALU core with a valid/ready handshake on both input and output. It supports NOP, add, subtract, bitwise logic, iterative unsigned multiply and iterative unsigned divide. Single-cycle operations complete in one cycle. MUL/DIV run through a shift-add or restoring-divide datapath over WIDTH cycles. It is the sequential successor to the combinational per-operation modules and sits between the operand/opcode source and the result writeback.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥ 2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  opcode/operands valid.
- in_ready  out  1  core can accept; equals 1 only in IDLE.
- opcode  in  3  operation select (encoding below).
- opA  in  WIDTH  operand A (unsigned; signed view for overflow).
- opB  in  WIDTH  operand B.
- out_valid  out  1  result/flags valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  low result word / quotient.
- result_hi  out  WIDTH  MUL high word / DIV remainder; 0 for other ops.
- flags  out  4  {dbz, ovf, carry, zero} (bit 3..0).

## Operation
- Opcodes:
  - 000 NOP: result 0, flags all 0.
  - 001 ADD.
  - 010 SUB: opA − opB.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 MUL: unsigned, 2·WIDTH product in {result_hi, result}.
  - 111 DIV: unsigned; quotient in result, remainder in result_hi.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: accept when in_valid && in_ready. Operands and opcode are latched on that edge; later changes to the inputs are ignored.
  - IDLE → DONE: NOP, ADD, SUB, logic ops, and DIV with opB == 0.
  - IDLE → BUSY: MUL; DIV with opB ≠ 0. An iteration counter loads WIDTH.
  - BUSY: one shift-add (MUL) or restore step (DIV) per cycle. Counter decrements; at 0 → DONE.
  - DONE: out_valid = 1. On out_ready = 1 → IDLE (out_valid drops next cycle). No new accept in the same cycle.
- Width rules:
  - ADD/SUB are computed at WIDTH+1 bits.
  - result is truncated to WIDTH bits.
- Flags:
  - zero: for MUL, the full product == 0; for NOP, 0; otherwise result == 0.
  - carry: ADD carry-out; SUB borrow (opA < opB); 0 for other ops.
  - ovf: ADD/SUB two's-complement signed overflow; MUL result_hi ≠ 0; 0 for other ops.
  - dbz: 1 only for DIV with opB == 0.
- Divide by zero: result = all ones, result_hi = opA, dbz = 1, zero = 0.
- result, result_hi and flags are registered and stable for the whole of DONE. Their values outside DONE are don't-care, except after reset.
- Reset, at the first edge with rst = 1, from any state:
  - state → IDLE, out_valid = 0.
  - result = 0, result_hi = 0, flags = 0.
  - The iteration counter is cleared and any in-flight operation is dropped with no output.
- rst has priority over any in_valid or out_ready asserted in the same cycle.

## Timing
- Latency is measured from the accept edge to the first cycle with out_valid = 1:
  - 1 cycle for NOP/ADD/SUB/logic and DIV-by-zero.
  - WIDTH + 1 cycles for MUL and DIV.
- Throughput: one operation per (latency + 1) cycles, given out_ready held high.
- in_ready is decoded from the registered state. It is 1 on the first cycle after rst deasserts.
- Backpressure: with out_ready = 0, the core stays in DONE indefinitely. in_ready = 0, and in_valid is ignored.
- No combinational path from in_valid/opA/opB to any output. out_ready affects only the next-state logic.

## Test plan
All scenarios use WIDTH = 8.
- **NOP, ADD, AND.**
  - NOP opA = 15, opB = 3 → result 0, result_hi 0, flags 0, out_valid one cycle after accept.
  - ADD 200 + 100 → result 44, carry 1, ovf 0.
  - AND 0xF0 & 0x3C → result 0x30.
- **SUB.**
  - 5 − 7 → result 254, carry 1, ovf 0.
  - 128 − 1 → result 127, ovf 1.
  - 9 − 9 → result 0, zero 1.
- **MUL.**
  - 15 × 3 → result 45, result_hi 0, ovf 0, out_valid exactly 9 cycles after accept.
  - 255 × 255 → result 0x01, result_hi 0xFE, ovf 1.
- **DIV.**
  - 200 / 7 → result 28, result_hi 4, dbz 0 at 9 cycles.
  - 9 / 0 → result 255, result_hi 9, dbz 1, out_valid 1 cycle after accept.
- **Backpressure.**
  - ADD 1 + 1 with out_ready held 0 for 5 cycles → out_valid, result 2 and flags stable; in_ready 0.
  - A toggled in_valid with new operands during those cycles is ignored.
  - out_ready = 1 → IDLE next cycle.
- **Reset mid-operation.**
  - Start MUL 15 × 3; assert rst on the 3rd BUSY cycle → next cycle IDLE, out_valid 0, result 0, in_ready 1 after rst deasserts.
  - A following ADD 2 + 3 returns 5 with normal latency.

Source files
------------

// File: rtl/alu_seq_core_if.sv
// Operand/opcode request and result/flags response bundle for alu_seq_core.
// The master drives requests and accepts results; the slave is the core.
interface alu_seq_core_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;

    modport master (
        output in_valid, opcode, opA, opB, out_ready,
        input  in_ready, out_valid, result, result_hi, flags
    );

    modport slave (
        input  in_valid, opcode, opA, opB, out_ready,
        output in_ready, out_valid, result, result_hi, flags
    );
endinterface

// File: rtl/alu_seq_core.sv
// Multi-cycle ALU: single-cycle add/sub/logic, iterative shift-add MUL and
// restoring DIV, valid/ready on both sides, all results registered.
module alu_seq_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_core_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_MUL = 3'b110,
        OP_DIV = 3'b111
    } op_t;

    state_t           state_q;
    logic             is_div_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CW-1:0]    cnt_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic [3:0]       flags_q;

    op_t              op_in;
    logic             need_iter;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] alu_res_d;
    logic [WIDTH-1:0] alu_hi_d;
    logic             alu_carry_d;
    logic             alu_ovf_d;
    logic             alu_dbz_d;
    logic             alu_zero_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_trial;
    logic             div_ok;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [3:0]       iter_flags_d;

    assign op_in     = op_t'(bus.opcode);
    assign need_iter = (op_in == OP_MUL) || ((op_in == OP_DIV) && (bus.opB != '0));

    // Single-cycle datapath, evaluated from the live inputs at the accept edge.
    always_comb begin
        add_w       = {1'b0, bus.opA} + {1'b0, bus.opB};
        sub_w       = {1'b0, bus.opA} - {1'b0, bus.opB};
        alu_res_d   = '0;
        alu_hi_d    = '0;
        alu_carry_d = 1'b0;
        alu_ovf_d   = 1'b0;
        alu_dbz_d   = 1'b0;
        unique case (op_in)
            OP_NOP: ;
            OP_ADD: begin
                alu_res_d   = add_w[WIDTH-1:0];
                alu_carry_d = add_w[WIDTH];
                alu_ovf_d   = (bus.opA[WIDTH-1] == bus.opB[WIDTH-1]) &&
                              (add_w[WIDTH-1] != bus.opA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_d   = sub_w[WIDTH-1:0];
                alu_carry_d = sub_w[WIDTH];
                alu_ovf_d   = (bus.opA[WIDTH-1] != bus.opB[WIDTH-1]) &&
                              (sub_w[WIDTH-1] != bus.opA[WIDTH-1]);
            end
            OP_AND: alu_res_d = bus.opA & bus.opB;
            OP_OR:  alu_res_d = bus.opA | bus.opB;
            OP_XOR: alu_res_d = bus.opA ^ bus.opB;
            OP_MUL: ;
            OP_DIV: begin
                alu_res_d = '1;
                alu_hi_d  = bus.opA;
                alu_dbz_d = 1'b1;
            end
            default: ;
        endcase
        alu_zero_d = (op_in != OP_NOP) && (alu_res_d == '0);
    end

    // One iteration step. MUL: hi_q accumulates, lo_q holds the multiplier
    // and collects product bits from the top. DIV: hi_q is the partial
    // remainder, lo_q shifts the dividend out and the quotient in.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh    = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_sh - {1'b0, opnd_q};
        div_ok    = ~div_trial[WIDTH];
        if (is_div_q) begin
            hi_d = div_ok ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ok};
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (is_div_q) begin
            iter_flags_d = {3'b000, (lo_d == '0)};
        end else begin
            iter_flags_d = {1'b0, (hi_d != '0), 1'b0, ({hi_d, lo_d} == '0)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            is_div_q    <= 1'b0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (need_iter) begin
                            state_q  <= BUSY;
                            cnt_q    <= CW'(WIDTH);
                            is_div_q <= (op_in == OP_DIV);
                            opnd_q   <= (op_in == OP_DIV) ? bus.opB : bus.opA;
                            lo_q     <= (op_in == OP_DIV) ? bus.opA : bus.opB;
                            hi_q     <= '0;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res_d;
                            result_hi_q <= alu_hi_d;
                            flags_q     <= {alu_dbz_d, alu_ovf_d, alu_carry_d, alu_zero_d};
                        end
                    end
                end
                BUSY: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - CW'(1);
                    // The final step's result is written straight to the outputs.
                    if (cnt_q == CW'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= lo_d;
                        result_hi_q <= hi_d;
                        flags_q     <= iter_flags_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (WIDTH = 8): directed cases, random
// ops against an arithmetic reference model, backpressure, reset, streaming.
module tb_alu_seq_core;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_seq_core_if #(.WIDTH(8)) bus ();

    alu_seq_core #(.WIDTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [7:0] h;
        logic [3:0] f;
        logic [7:0] lat;
    } vec_t;

    vec_t dir_vec [16] = '{
        '{3'd0, 8'd15,   8'd3,   8'd0,    8'd0,    4'b0000, 8'd1},
        '{3'd1, 8'd200,  8'd100, 8'd44,   8'd0,    4'b0010, 8'd1},
        '{3'd3, 8'hF0,   8'h3C,  8'h30,   8'd0,    4'b0000, 8'd1},
        '{3'd4, 8'hA0,   8'h05,  8'hA5,   8'd0,    4'b0000, 8'd1},
        '{3'd5, 8'h55,   8'h55,  8'h00,   8'd0,    4'b0001, 8'd1},
        '{3'd2, 8'd5,    8'd7,   8'd254,  8'd0,    4'b0010, 8'd1},
        '{3'd2, 8'd128,  8'd1,   8'd127,  8'd0,    4'b0100, 8'd1},
        '{3'd2, 8'd9,    8'd9,   8'd0,    8'd0,    4'b0001, 8'd1},
        '{3'd1, 8'd127,  8'd1,   8'd128,  8'd0,    4'b0100, 8'd1},
        '{3'd6, 8'd15,   8'd3,   8'd45,   8'd0,    4'b0000, 8'd9},
        '{3'd6, 8'd255,  8'd255, 8'h01,   8'hFE,   4'b0100, 8'd9},
        '{3'd6, 8'd0,    8'd77,  8'd0,    8'd0,    4'b0001, 8'd9},
        '{3'd7, 8'd200,  8'd7,   8'd28,   8'd4,    4'b0000, 8'd9},
        '{3'd7, 8'd9,    8'd0,   8'd255,  8'd9,    4'b1000, 8'd1},
        '{3'd7, 8'd3,    8'd7,   8'd0,    8'd3,    4'b0001, 8'd9},
        '{3'd7, 8'd255,  8'd1,   8'd255,  8'd0,    4'b0000, 8'd9}
    };

    function automatic void ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                      output logic [7:0] r, output logic [7:0] h, output logic [3:0] f);
        int ia, ib, sa, sb, s;
        logic z, c, v, d;
        ia = int'(a);
        ib = int'(b);
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        r = 8'd0; h = 8'd0; c = 1'b0; v = 1'b0; d = 1'b0;
        case (op)
            3'd1: begin s = ia + ib; r = 8'(s); c = (s > 255); v = ((sa + sb) > 127) || ((sa + sb) < -128); end
            3'd2: begin s = ia - ib; r = 8'(s); c = (ia < ib); v = ((sa - sb) > 127) || ((sa - sb) < -128); end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin s = ia * ib; r = 8'(s % 256); h = 8'(s / 256); v = (s >= 256); end
            3'd7: begin
                if (ib == 0) begin r = 8'hFF; h = a; d = 1'b1; end
                else begin r = 8'(ia / ib); h = 8'(ia % ib); end
            end
            default: ;
        endcase
        if (op == 3'd0)      z = 1'b0;
        else if (op == 3'd6) z = (ia * ib == 0);
        else                 z = (r == 8'd0);
        f = {d, v, c, z};
    endfunction

    // Drives one transaction starting at a negedge; returns observed outputs
    // and latency (-1 if out_valid never came). Ends at a negedge in IDLE.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic [7:0] h, output logic [3:0] f,
                          output int lat);
        int guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid  = 1'b1;
        bus.opcode    = op;
        bus.opA       = a;
        bus.opB       = b;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.opcode   = 3'($urandom);
        bus.opA      = 8'($urandom);
        bus.opB      = 8'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 40);
        if (!bus.out_valid) lat = -1;
        r = bus.result;
        h = bus.result_hi;
        f = bus.flags;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.opcode = 3'd0; bus.opA = 8'd0; bus.opB = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++;
        if (bus.result !== 8'd0 || bus.result_hi !== 8'd0) begin
            n_fail++; $display("FAIL reset_result: got %h/%h want 00/00", bus.result_hi, bus.result);
        end
        n_checks++;
        if (bus.flags !== 4'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", bus.flags); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [7:0] r, h;
        logic [3:0] f;
        int lat;
        foreach (dir_vec[i]) begin
            run_op(dir_vec[i].op, dir_vec[i].a, dir_vec[i].b, r, h, f, lat);
            n_checks++;
            if (r !== dir_vec[i].r) begin n_fail++; $display("FAIL dir%0d_result: got %0d want %0d", i, r, dir_vec[i].r); end
            n_checks++;
            if (h !== dir_vec[i].h) begin n_fail++; $display("FAIL dir%0d_result_hi: got %0d want %0d", i, h, dir_vec[i].h); end
            n_checks++;
            if (f !== dir_vec[i].f) begin n_fail++; $display("FAIL dir%0d_flags: got %b want %b", i, f, dir_vec[i].f); end
            n_checks++;
            if (lat != int'(dir_vec[i].lat)) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, dir_vec[i].lat); end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, r, h, er, eh;
        logic [3:0] f, ef;
        logic [2:0] op;
        int lat, elat;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom);
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            ref_model(op, a, b, er, eh, ef);
            elat = ((op == 3'd6) || (op == 3'd7 && b != 8'd0)) ? 9 : 1;
            run_op(op, a, b, r, h, f, lat);
            n_checks++;
            if (r !== er) begin n_fail++; $display("FAIL rnd_result op=%0d a=%0d b=%0d: got %0d want %0d", op, a, b, r, er); end
            n_checks++;
            if (h !== eh) begin n_fail++; $display("FAIL rnd_result_hi op=%0d a=%0d b=%0d: got %0d want %0d", op, a, b, h, eh); end
            n_checks++;
            if (f !== ef) begin n_fail++; $display("FAIL rnd_flags op=%0d a=%0d b=%0d: got %b want %b", op, a, b, f, ef); end
            n_checks++;
            if (lat != elat) begin n_fail++; $display("FAIL rnd_latency op=%0d: got %0d want %0d", op, lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        bus.in_valid = 1'b1; bus.opcode = 3'd1; bus.opA = 8'd1; bus.opB = 8'd1; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc%0d: got %b want 1", i, bus.out_valid); end
            n_checks++;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", i, bus.in_ready); end
            n_checks++;
            if (bus.result !== 8'd2 || bus.flags !== 4'd0) begin
                n_fail++; $display("FAIL bp_hold cyc%0d: got result %0d flags %b want 2 0000", i, bus.result, bus.flags);
            end
            bus.in_valid = (i % 2 == 0);
            bus.opcode   = 3'($urandom_range(1, 5));
            bus.opA      = 8'($urandom);
            bus.opB      = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got out_valid %b in_ready %b want 0 1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_ghost: got out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r, h;
        logic [3:0] f;
        int lat;
        int ghost = 0;
        bus.in_valid = 1'b1; bus.opcode = 3'd6; bus.opA = 8'd15; bus.opB = 8'd3; bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_state: got out_valid %b in_ready %b want 0 1", bus.out_valid, bus.in_ready);
        end
        n_checks++;
        if (bus.result !== 8'd0 || bus.result_hi !== 8'd0 || bus.flags !== 4'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %h/%h/%b want 00/00/0000", bus.result_hi, bus.result, bus.flags);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) ghost++;
            @(negedge clk);
        end
        n_checks++;
        if (ghost != 0) begin n_fail++; $display("FAIL rstmid_dropped: got %0d out_valid cycles want 0", ghost); end
        bus.out_ready = 1'b0;
        run_op(3'd1, 8'd2, 8'd3, r, h, f, lat);
        n_checks++;
        if (r !== 8'd5 || f !== 4'd0) begin n_fail++; $display("FAIL rstmid_add: got %0d flags %b want 5 0000", r, f); end
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL rstmid_add_latency: got %0d want 1", lat); end
    endtask

    task automatic test_back_to_back(input logic [2:0] op, input int cycles, input int exp_ops);
        int accepts = 0;
        int results = 0;
        logic [7:0] a, b, er, eh;
        logic [3:0] ef;
        a = 8'($urandom);
        b = 8'($urandom_range(1, 255));
        ref_model(op, a, b, er, eh, ef);
        bus.in_valid = 1'b1; bus.opcode = op; bus.opA = a; bus.opB = b; bus.out_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (bus.in_ready) accepts++;
            if (bus.out_valid) begin
                results++;
                n_checks++;
                if (bus.result !== er || bus.result_hi !== eh || bus.flags !== ef) begin
                    n_fail++;
                    $display("FAIL b2b_op%0d_data: got %h/%h/%b want %h/%h/%b", op, bus.result_hi, bus.result, bus.flags, eh, er, ef);
                end
            end
            @(negedge clk);
            if (i == cycles - 2) bus.in_valid = 1'b0;
        end
        n_checks++;
        if (accepts != exp_ops) begin n_fail++; $display("FAIL b2b_op%0d_accepts: got %0d want %0d", op, accepts, exp_ops); end
        n_checks++;
        if (results != exp_ops) begin n_fail++; $display("FAIL b2b_op%0d_results: got %0d want %0d", op, results, exp_ops); end
        bus.out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_op%0d_idle: got in_ready %b want 1", op, bus.in_ready); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back(3'd1, 20, 10);
        test_back_to_back(3'd6, 40, 4);
        test_back_to_back(3'd7, 40, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
